// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions.
//   div_state_t : control states of the iterative divider.
//   cnt_width() : width of a down-counter that must hold the value `width`.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Usable in localparam expressions: bits needed to hold 0..width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/divider_unsigned_step.sv
// One restoring-division step, purely combinational.
//   rem      : partial remainder entering the step (always < divisor)
//   q        : quotient shift register; its MSB is the next dividend bit
//   divisor  : nonzero divisor
//   rem_next : partial remainder after the step
//   q_next   : quotient register shifted left with the new quotient bit
module divider_unsigned_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    shifted = {rem, q[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    // A negative trial (bit WIDTH set) restores the shifted value. Either
    // way the kept value is below the divisor, so its top bit is zero and
    // only WIDTH bits need to travel back to the register.
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      q_next   = {q[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      q_next   = {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/divider_unsigned_seq.sv
// Iterative radix-2 restoring unsigned divider, WIDTH cycles per result.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (accepted only in IDLE)
//   dividend, divisor    : operands, sampled on accept
//   out_valid / out_ready: result handshake (result held until taken)
//   quotient, remainder  : result; divide by zero gives all ones / dividend
//   div_zero             : result came from a zero divisor
module divider_unsigned_seq
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = cnt_width(WIDTH);

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] rem_q, q_q, dvsr_q;
  logic [CW-1:0]    cnt_q;
  logic             dz_q;
  logic             accept;
  logic [WIDTH-1:0] rem_step, q_step;

  divider_unsigned_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .q        (q_q),
    .divisor  (dvsr_q),
    .rem_next (rem_step),
    .q_next   (q_step)
  );

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = (divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: the datapath is reset as well as the FSM, because the outputs
  // are driven straight from these registers and must read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      q_q    <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
      dz_q   <= 1'b0;
    end else if (accept) begin
      dvsr_q <= divisor;
      if (divisor == '0) begin
        rem_q <= dividend;
        q_q   <= '1;
        cnt_q <= '0;
        dz_q  <= 1'b1;
      end else begin
        rem_q <= '0;
        q_q   <= dividend;
        cnt_q <= CW'(WIDTH);
        dz_q  <= 1'b0;
      end
    end else if (state_q == RUN) begin
      rem_q <= rem_step;
      q_q   <= q_step;
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign quotient  = q_q;
  assign remainder = rem_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_divider_unsigned_seq.sv
module tb_divider_unsigned_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  int checks = 0;
  int errors = 0;

  divider_unsigned_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one operation and check latency, result, stall hold and handshake.
  task automatic run_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                           input int stall, input bit noise);
    int t;
    int lat;
    int exp_lat;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    check({name, " in_ready"}, 32'(in_ready), 32'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 4 * W) begin
      if (noise) begin
        in_valid = lat[0];
        dividend = ~a;
        divisor  = 8'd1;
      end
      @(posedge clk); #1;
      lat++;
    end
    exp_lat = (b == '0) ? 0 : W;
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " quotient"}, 32'(quotient), 32'(eq));
    check({name, " remainder"}, 32'(remainder), 32'(er));
    check({name, " div_zero"}, 32'(div_zero), 32'(edz));
    for (int s = 0; s < stall; s++) begin
      if (noise) begin
        in_valid = 1'b1;
        dividend = 8'd3;
        divisor  = 8'd1;
      end
      @(posedge clk); #1;
      check({name, " held"}, {22'd0, out_valid, div_zero, quotient, remainder},
            {22'd0, 1'b1, edz, eq, er});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, " ready after take"}, {30'd0, in_ready, out_valid}, 32'b10);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{a: 8'd200, b: 8'd7,   q: 8'd28,  r: 8'd4,  dz: 1'b0};
    vecs[1] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,  dz: 1'b0};
    vecs[2] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,  dz: 1'b0};
    vecs[3] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,  dz: 1'b0};
    vecs[4] = '{a: 8'd0,   b: 8'd3,   q: 8'd0,   r: 8'd0,  dz: 1'b0};
    vecs[5] = '{a: 8'd77,  b: 8'd0,   q: 8'd255, r: 8'd77, dz: 1'b1};
    vecs[6] = '{a: 8'd10,  b: 8'd3,   q: 8'd3,   r: 8'd1,  dz: 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset state", {19'd0, in_ready, out_valid, div_zero, quotient, remainder},
          {19'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0});
    rst = 1'b0;

    // Directed vectors, including divide-by-zero followed by a normal divide.
    for (int i = 0; i < 7; i++)
      run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                vecs[i].dz, 0, 1'b0);

    // Backpressure with spurious in_valid while busy.
    run_check("backpressure", 8'd100, 8'd9, 8'd11, 8'd1, 1'b0, 5, 1'b1);

    // Reset in the middle of RUN discards the operation.
    begin
      int bad;
      dividend = 8'd123;
      divisor  = 8'd5;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("midrun busy", {30'd0, in_ready, out_valid}, 32'b00);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrun reset", {19'd0, in_ready, out_valid, div_zero, quotient, remainder},
            {19'd0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0});
      bad = 0;
      repeat (12) begin
        @(posedge clk); #1;
        if (out_valid) bad++;
      end
      check("midrun no valid", 32'(bad), 32'd0);
      run_check("after reset", 8'd50, 8'd6, 8'd8, 8'd2, 1'b0, 0, 1'b0);
    end

    // Random sweep against the arithmetic reference model.
    for (int n = 0; n < 3000; n++) begin
      logic [W-1:0] a, b, eq, er;
      logic         edz;
      a = W'($urandom_range(0, 255));
      b = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom_range(0, 255));
      if (b == '0) begin
        eq  = '1;
        er  = a;
        edz = 1'b1;
      end else begin
        eq  = a / b;
        er  = a % b;
        edz = 1'b0;
      end
      run_check($sformatf("rand %0d/%0d", a, b), a, b, eq, er, edz, n % 3, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
